load_align_extender: RTL and testbench
======================================

LOAD_ALIGN_EXTENDER -- requirements
Module: load_align_extender

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the memory word width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter BIG_ENDIAN, default 1, meaning 1 = MIPS big-endian lane numbering and 0 = little-endian.
REQ-003 The block SHALL have parameter ERR_CNT_WIDTH, default 16, meaning the width of the misalignment counter.
REQ-004 The ports SHALL be, in order (name  direction  width  meaning):
- clk  in  1  the single clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle.
- in_word  in  DATA_WIDTH  raw memory word.
- in_offset  in  OFFW = log2(DATA_WIDTH/8)  byte address within the word.
- in_size  in  2  0 = byte, 1 = half, 2 = full word, 3 = reserved.
- in_signExtend  in  1  1 = fill with sign bit, 0 = zero fill.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_WIDTH  aligned, extended result.
- out_misaligned  out  1  the request was misaligned or reserved.
- err_count  out  ERR_CNT_WIDTH  saturating count of misaligned requests accepted.

Function
REQ-005 An input transfer SHALL occur on a rising edge of clk when in_valid && in_ready.
REQ-006 An output transfer SHALL occur on a rising edge of clk when out_valid && out_ready.
REQ-007 Lane selection: lane index L = in_offset when BIG_ENDIAN = 0; otherwise L = (DATA_WIDTH/8 - 1 - in_offset) for a byte and (DATA_WIDTH/16 - 1 - in_offset/2) for a half; a byte occupies in_word bits [8L+7:8L] and a half occupies bits [16L+15:16L].
REQ-008 The selected byte or half SHALL be placed in the low bits of out_data; the upper bits SHALL be set to its MSB when in_signExtend = 1 and to 0 otherwise.
REQ-009 A full-word request (in_size = 2) SHALL pass in_word through unchanged, ignoring in_signExtend.
REQ-010 A request SHALL be misaligned when any of the following holds, in which case out_data = 0 and out_misaligned = 1:
- in_size = 1 with in_offset[0] = 1;
- in_size = 2 with in_offset != 0;
- in_size = 3.
REQ-011 Latency SHALL be exactly 1 cycle: a request accepted at edge N appears on out_valid and out_data after edge N when the output stage is empty or draining.
REQ-012 The block SHALL contain a main output register and one skid register; in_ready SHALL be registered and equal to NOT skid_valid.
REQ-013 Each clock edge SHALL update the storage as follows:
- An accept while the main register is empty or being drained loads the main register.
- An accept while the main register is stalled (out_valid && !out_ready) loads the skid register.
- When the main register drains and the skid register is full, the skid contents SHALL move into the main register in that same cycle.
REQ-014 The block SHALL sustain throughput of 1 request per cycle when out_ready = 1 continuously.
REQ-015 Output ordering SHALL equal acceptance order, with no loss and no duplication.
REQ-016 out_data and out_misaligned SHALL hold stable while out_valid && !out_ready.
REQ-017 err_count SHALL increment by 1 on each accepted misaligned request and saturate at all-ones.
REQ-018 A simultaneous accept and drain SHALL change no occupancy: the new result replaces the drained one.

Reset
REQ-019 While reset = 1 at a clock edge, the block SHALL apply all of the following:
- out_valid = 0, skid_valid = 0, in_ready = 1 on the next cycle;
- out_data = 0, out_misaligned = 0, err_count = 0;
- any request presented in that cycle is not accepted.
REQ-020 Reset asserted mid-stream SHALL discard both stored entries with no partial output.

Verification
REQ-021 With DATA_WIDTH = 32, BIG_ENDIAN = 1, the bench SHALL apply word 0x80FF7F01, size 0, offset 0, signExtend 1 -> out_data 0xFFFFFF80; with offset 3, signExtend 0 -> 0x00000001.
REQ-022 With DATA_WIDTH = 32, BIG_ENDIAN = 0, the bench SHALL apply word 0x8001_7FFF, size 1, offset 2, signExtend 1 -> 0xFFFF8001; with offset 0 -> 0x00007FFF.
REQ-023 The bench SHALL apply size 1, offset 1 and size 3 -> out_data 0 and out_misaligned 1 for each, with err_count going 0 -> 1 -> 2; it SHALL then preload err_count near saturation and confirm it saturates.
REQ-024 The bench SHALL hold out_ready = 0 and stream 3 requests -> 2 accepted, in_ready = 0 on the cycle after the second accept, outputs stable; it SHALL then release out_ready -> the 3 results emerge in order with no gaps after release.
REQ-025 The bench SHALL apply DATA_WIDTH = 64, BIG_ENDIAN = 1, word 0x0123456789ABCDEF, size 0, offset 7, signExtend 1 -> 0xFFFFFFFFFFFFFFEF.
REQ-026 The bench SHALL assert reset with both registers full -> next cycle out_valid 0, in_ready 1, err_count 0, and no stale data ever presented.

Source files
------------

// File: rtl/load_align_extender.sv
// load_align_extender
//
// Extracts a byte, half-word or full word from a raw memory word and
// right-aligns it. Bytes and halves are then sign- or zero-extended.
// Misaligned or reserved requests produce zero data, raise out_misaligned
// and bump a saturating error counter.
//
// The output stage is a main register backed by one skid register. in_ready
// is registered, so the upstream never sees a combinational path from
// out_ready. Throughput is one request per cycle while out_ready stays high.
//
// Ports
//   clk, reset      single clock; synchronous active-high reset
//   in_valid/ready  request handshake (transfer when both high at an edge)
//   in_word         raw memory word
//   in_offset       byte address within the word
//   in_size         0 = byte, 1 = half, 2 = full word, 3 = reserved
//   in_signExtend   1 = sign fill, 0 = zero fill (ignored for full word)
//   out_valid/ready result handshake
//   out_data        aligned, extended result (0 when misaligned)
//   out_misaligned  request was misaligned or reserved
//   err_count       saturating count of accepted misaligned requests
module load_align_extender #(
    parameter int DATA_WIDTH    = 32,
    parameter bit BIG_ENDIAN    = 1'b1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_word,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]  in_offset,
    input  logic [1:0]                       in_size,
    input  logic                             in_signExtend,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_misaligned,
    output logic [ERR_CNT_WIDTH-1:0]         err_count
);
    localparam int NBYTES  = DATA_WIDTH / 8;
    localparam int NHALVES = DATA_WIDTH / 16;
    localparam int OFFW    = $clog2(NBYTES);

    // ------------------------------------------------------------------
    // Lane extraction
    // ------------------------------------------------------------------
    logic [7:0]  byte_lane [NBYTES];
    logic [15:0] half_lane [NHALVES];
    logic [OFFW-1:0] byte_idx;
    logic [OFFW-2:0] half_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte_lane
            assign byte_lane[gi] = in_word[8*gi +: 8];
        end
        for (gi = 0; gi < NHALVES; gi++) begin : g_half_lane
            assign half_lane[gi] = in_word[16*gi +: 16];
        end

        // The lane counts are powers of two, so "count - 1 - idx" is simply
        // the bitwise inverse of idx.
        if (BIG_ENDIAN) begin : g_be
            assign byte_idx = ~in_offset;
            assign half_idx = ~in_offset[OFFW-1:1];
        end else begin : g_le
            assign byte_idx = in_offset;
            assign half_idx = in_offset[OFFW-1:1];
        end
    endgenerate

    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  res_mis;

    assign sel_byte = byte_lane[byte_idx];
    assign sel_half = half_lane[half_idx];

    always_comb begin
        res_data = '0;
        res_mis  = 1'b0;
        case (in_size)
            2'd0: res_data = {{(DATA_WIDTH-8){in_signExtend & sel_byte[7]}}, sel_byte};
            2'd1: begin
                if (in_offset[0]) begin
                    res_mis = 1'b1;
                end else begin
                    res_data = {{(DATA_WIDTH-16){in_signExtend & sel_half[15]}}, sel_half};
                end
            end
            2'd2: begin
                if (in_offset != '0) begin
                    res_mis = 1'b1;
                end else begin
                    res_data = in_word;
                end
            end
            default: res_mis = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage: main register + skid register
    // ------------------------------------------------------------------
    logic                     main_valid_reg, main_valid_next;
    logic [DATA_WIDTH-1:0]    main_data_reg,  main_data_next;
    logic                     main_mis_reg,   main_mis_next;
    logic                     skid_valid_reg, skid_valid_next;
    logic [DATA_WIDTH-1:0]    skid_data_reg,  skid_data_next;
    logic                     skid_mis_reg,   skid_mis_next;
    logic                     in_ready_reg,   in_ready_next;
    logic [ERR_CNT_WIDTH-1:0] err_count_reg,  err_count_next;

    logic accept;
    logic main_free;

    assign accept    = in_valid && in_ready_reg;
    // Main register can take new contents: empty, or draining this edge.
    assign main_free = !main_valid_reg || out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        main_mis_next   = main_mis_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_mis_next   = skid_mis_reg;
        err_count_next  = err_count_reg;

        if (main_free) begin
            if (skid_valid_reg) begin
                // in_ready is low while the skid is full, so no accept can
                // coincide with this refill.
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                main_mis_next   = skid_mis_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_valid_next = 1'b1;
                main_data_next  = res_data;
                main_mis_next   = res_mis;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = res_data;
            skid_mis_next   = res_mis;
        end

        if (accept && res_mis && !(&err_count_reg)) begin
            err_count_next = err_count_reg + ERR_CNT_WIDTH'(1);
        end

        in_ready_next = !skid_valid_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_mis_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_mis_reg   <= 1'b0;
            in_ready_reg   <= 1'b1;
            err_count_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            main_mis_reg   <= main_mis_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_mis_reg   <= skid_mis_next;
            in_ready_reg   <= in_ready_next;
            err_count_reg  <= err_count_next;
        end
    end

    assign in_ready       = in_ready_reg;
    assign out_valid      = main_valid_reg;
    assign out_data       = main_data_reg;
    assign out_misaligned = main_mis_reg;
    assign err_count      = err_count_reg;

endmodule

// File: tb/tb_load_align_extender.sv
// Testbench for load_align_extender.
// Three instances share one request/response handshake:
//   0: 32-bit big-endian, 16-bit error counter
//   1: 32-bit little-endian, 3-bit error counter (reaches saturation quickly)
//   2: 64-bit big-endian, 16-bit error counter
// A per-instance reference model (ordered list of expected results, occupancy
// count, error count) is checked against the outputs on every falling edge.
module tb_load_align_extender;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] word = '0;
    logic [2:0]  off = '0;
    logic [1:0]  size = '0;
    logic        sext = 1'b0;

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        om0, om1, om2;
    logic [31:0] od0, od1;
    logic [63:0] od2;
    logic [15:0] ec0, ec2;
    logic [2:0]  ec1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_align_extender #(.DATA_WIDTH(32), .BIG_ENDIAN(1'b1), .ERR_CNT_WIDTH(16)) u_be32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
        .in_word(word[31:0]), .in_offset(off[1:0]), .in_size(size), .in_signExtend(sext),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_misaligned(om0),
        .err_count(ec0));

    load_align_extender #(.DATA_WIDTH(32), .BIG_ENDIAN(1'b0), .ERR_CNT_WIDTH(3)) u_le32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
        .in_word(word[31:0]), .in_offset(off[1:0]), .in_size(size), .in_signExtend(sext),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_misaligned(om1),
        .err_count(ec1));

    load_align_extender #(.DATA_WIDTH(64), .BIG_ENDIAN(1'b1), .ERR_CNT_WIDTH(16)) u_be64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
        .in_word(word), .in_offset(off), .in_size(size), .in_signExtend(sext),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_misaligned(om2),
        .err_count(ec2));

    // ------------------------------------------------------------------
    // Comparison helper
    // ------------------------------------------------------------------
    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int inst_dw(input int k);
        return (k == 2) ? 64 : 32;
    endfunction

    function automatic bit inst_be(input int k);
        return (k != 1);
    endfunction

    function automatic int inst_errmax(input int k);
        return (k == 1) ? 7 : 65535;
    endfunction

    // Returns {misaligned, data}. Byte/half positions are computed from the
    // memory byte address: in big-endian, byte address 0 is the most
    // significant byte, so an item of n bytes at address a starts
    // (nbytes - n - a) bytes up from bit 0.
    function automatic logic [64:0] model(input int k, input logic [63:0] w,
                                          input logic [2:0] o, input logic [1:0] s,
                                          input logic se);
        int          dw;
        int          nb;
        int          a;
        int          pos;
        bit          mis;
        logic [63:0] wm;
        logic [63:0] v;
        dw  = inst_dw(k);
        nb  = dw / 8;
        a   = int'(o) % nb;
        wm  = (dw == 32) ? {32'b0, w[31:0]} : w;
        v   = '0;
        mis = (s == 2'd3) || (s == 2'd1 && (a % 2) == 1) || (s == 2'd2 && a != 0);
        if (mis) return {1'b1, 64'b0};
        if (s == 2'd0) begin
            pos = inst_be(k) ? (nb - 1 - a) * 8 : a * 8;
            v = (wm >> pos) & 64'hFF;
            if (se && v[7]) v = v | ~64'hFF;
        end else if (s == 2'd1) begin
            pos = inst_be(k) ? (nb - 2 - a) * 8 : a * 8;
            v = (wm >> pos) & 64'hFFFF;
            if (se && v[15]) v = v | ~64'hFFFF;
        end else begin
            v = wm;
        end
        if (dw == 32) v = v & 64'hFFFF_FFFF;
        return {1'b0, v};
    endfunction

    logic [64:0] mq [3][2];
    int          mcnt [3];
    int          merr [3];
    bit          clean [3];
    bit          armed = 1'b0;

    task automatic mon_inst(input int k, input logic ov, input logic ir,
                            input logic [63:0] od, input logic om, input logic [63:0] ec);
        bit take;
        if (armed) begin
            cmp($sformatf("out_valid[%0d]", k), {63'b0, ov}, {63'b0, mcnt[k] > 0});
            cmp($sformatf("in_ready[%0d]", k), {63'b0, ir}, {63'b0, mcnt[k] < 2});
            cmp($sformatf("err_count[%0d]", k), ec, 64'(merr[k]));
            if (mcnt[k] > 0) begin
                cmp($sformatf("out_data[%0d]", k), od, mq[k][0][63:0]);
                cmp($sformatf("out_misaligned[%0d]", k), {63'b0, om}, {63'b0, mq[k][0][64]});
            end else if (clean[k]) begin
                cmp($sformatf("idle_data[%0d]", k), od, 64'h0);
                cmp($sformatf("idle_mis[%0d]", k), {63'b0, om}, 64'h0);
            end
        end
        if (reset) begin
            mcnt[k]  = 0;
            merr[k]  = 0;
            clean[k] = 1'b1;
        end else if (armed) begin
            // Acceptance depends on occupancy before any drain this edge.
            take = in_valid && (mcnt[k] < 2);
            if (out_ready && mcnt[k] > 0) begin
                mq[k][0] = mq[k][1];
                mcnt[k]--;
            end
            if (take) begin
                mq[k][mcnt[k]] = model(k, word, off, size, sext);
                if (mq[k][mcnt[k]][64] && merr[k] < inst_errmax(k)) merr[k]++;
                mcnt[k]++;
                clean[k] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_inst(0, ov0, ir0, {32'b0, od0}, om0, {48'b0, ec0});
        mon_inst(1, ov1, ir1, {32'b0, od1}, om1, {61'b0, ec1});
        mon_inst(2, ov2, ir2, od2, om2, {48'b0, ec2});
        if (reset) armed = 1'b1;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all entered/left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Present one request and hold it until it is accepted.
    task automatic send(input logic [63:0] w, input logic [2:0] o,
                        input logic [1:0] s, input logic se);
        bit got;
        word = w; off = o; size = s; sext = se;
        in_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = ir0;
            step();
        end
        if (!got) cmp("send_timeout", 64'h0, 64'h1);
        in_valid = 1'b0;
    endtask

    logic [31:0] stall_words [3];
    int          acc;
    bit          acc_now;

    initial begin
        stall_words[0] = 32'h1111_1111;
        stall_words[1] = 32'h2222_2222;
        stall_words[2] = 32'h3333_3333;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        cmp("rst_out_valid", {63'b0, ov0}, 64'h0);
        cmp("rst_in_ready", {63'b0, ir0}, 64'h1);
        cmp("rst_err_count", {48'b0, ec0}, 64'h0);
        cmp("rst_out_data", {32'b0, od0}, 64'h0);
        step();

        // Big-endian byte extraction, 32-bit
        send(64'h80FF7F01, 3'd0, 2'd0, 1'b1);
        @(negedge clk);
        cmp("be32_byte0_valid", {63'b0, ov0}, 64'h1);
        cmp("be32_byte0_sext", {32'b0, od0}, 64'hFFFF_FF80);
        step();
        send(64'h80FF7F01, 3'd3, 2'd0, 1'b0);
        @(negedge clk);
        cmp("be32_byte3_zext", {32'b0, od0}, 64'h0000_0001);
        step();

        // Little-endian half extraction, 32-bit
        send(64'h8001_7FFF, 3'd2, 2'd1, 1'b1);
        @(negedge clk);
        cmp("le32_half2_sext", {32'b0, od1}, 64'hFFFF_8001);
        step();
        send(64'h8001_7FFF, 3'd0, 2'd1, 1'b1);
        @(negedge clk);
        cmp("le32_half0_sext", {32'b0, od1}, 64'h0000_7FFF);
        step();

        // Big-endian byte extraction, 64-bit
        send(64'h0123_4567_89AB_CDEF, 3'd7, 2'd0, 1'b1);
        @(negedge clk);
        cmp("be64_byte7_sext", od2, 64'hFFFF_FFFF_FFFF_FFEF);
        step();

        // Misaligned and reserved requests, error counter
        do_reset();
        @(negedge clk);
        cmp("err_start", {48'b0, ec0}, 64'h0);
        step();
        send(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 2'd1, 1'b1);
        @(negedge clk);
        cmp("mis_half_data", {32'b0, od0}, 64'h0);
        cmp("mis_half_flag", {63'b0, om0}, 64'h1);
        cmp("mis_half_err", {48'b0, ec0}, 64'h1);
        step();
        send(64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 2'd3, 1'b0);
        @(negedge clk);
        cmp("mis_rsvd_data", {32'b0, od0}, 64'h0);
        cmp("mis_rsvd_flag", {63'b0, om0}, 64'h1);
        cmp("mis_rsvd_err", {48'b0, ec0}, 64'h2);
        step();
        // Drive the 3-bit counter of instance 1 past its maximum.
        for (int i = 0; i < 6; i++) send(64'h0, 3'd0, 2'd3, 1'b0);
        @(negedge clk);
        cmp("err_saturated", {61'b0, ec1}, 64'h7);
        cmp("err_counting", {48'b0, ec0}, 64'h8);
        step();

        // Back-pressure: three requests against a stalled output
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        word = {32'b0, stall_words[0]}; off = 3'd0; size = 2'd2; sext = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc_now = ir0;
            step();
            if (acc_now) begin
                acc++;
                if (acc < 3) word = {32'b0, stall_words[acc]};
            end
        end
        @(negedge clk);
        cmp("stall_accepts", 64'(acc), 64'h2);
        cmp("stall_in_ready", {63'b0, ir0}, 64'h0);
        cmp("stall_head", {32'b0, od0}, {32'b0, stall_words[0]});
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp($sformatf("release_valid%0d", i), {63'b0, ov0}, 64'h1);
            cmp($sformatf("release_data%0d", i), {32'b0, od0}, {32'b0, stall_words[i]});
            acc_now = in_valid && ir0;
            step();
            if (acc_now) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        repeat (2) step();

        // Reset with both registers full
        out_ready = 1'b0;
        send(64'hDEAD_BEEF_DEAD_BEEF, 3'd0, 2'd2, 1'b0);
        send(64'h0, 3'd0, 2'd3, 1'b0);
        @(negedge clk);
        cmp("full_in_ready", {63'b0, ir0}, 64'h0);
        step();
        reset = 1'b1;
        in_valid = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        cmp("midrst_out_valid", {63'b0, ov0}, 64'h0);
        cmp("midrst_in_ready", {63'b0, ir0}, 64'h1);
        cmp("midrst_err", {48'b0, ec0}, 64'h0);
        cmp("midrst_data", {32'b0, od0}, 64'h0);
        step();
        out_ready = 1'b1;
        repeat (3) step();

        // Throughput: continuous requests with out_ready held high
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 100; i++) begin
            word = {$urandom, $urandom};
            off  = 3'($urandom_range(0, 7));
            size = 2'($urandom_range(0, 2));
            sext = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (ir0) acc++;
            step();
        end
        in_valid = 1'b0;
        cmp("throughput", 64'(acc), 64'd100);
        step();

        // Randomised traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            word      = {$urandom, $urandom};
            off       = 3'($urandom_range(0, 7));
            size      = 2'($urandom_range(0, 3));
            sext      = 1'($urandom_range(0, 1));
            step();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
